// File: rtl/job_dispatcher_pkg.sv
// Shared definitions for the job dispatcher: dispatcher FSM state encoding.
package job_dispatcher_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE  = 2'd0;
   localparam state_t START = 2'd1;
   localparam state_t CLEAR = 2'd2;

endpackage

// File: rtl/job_fifo.sv
// Circular job queue with registered occupancy; storage is not reset.
module job_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  full,
   output logic                  empty
);

   localparam int PtrW = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]       wr_ptr_q;
   logic [PtrW-1:0]       rd_ptr_q;
   logic [PtrW:0]         count_q;
   logic                  do_wr;
   logic                  do_rd;

   assign full    = (count_q == (PtrW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_rd   = rd_en && !empty;
   // A pop on the same edge frees the slot, so a full queue still takes the word.
   assign do_wr   = wr_en && (!full || do_rd);
   assign rd_data = mem_q[rd_ptr_q];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_wr) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (do_rd) rd_ptr_q <= rd_ptr_q + PtrW'(1);
         count_q <= count_q + (PtrW+1)'(do_wr) - (PtrW+1)'(do_rd);
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/job_dispatcher.sv
// Dispatches queued jobs one at a time to a downstream FSM via a go/done handshake,
// inserting a one-cycle go-low CLEAR phase after each completion.
module job_dispatcher
   import job_dispatcher_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int DEPTH       = 4,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DATA_WIDTH-1:0]  in_data,
   output logic                   go,
   input  logic                   done,
   output logic [DATA_WIDTH-1:0]  job_data,
   output logic                   busy,
   output logic [COUNT_WIDTH-1:0] job_count
);

   state_t                 state_q;
   state_t                 state_d;
   logic                   pending_q;
   logic                   go_q;
   logic                   busy_q;
   logic [COUNT_WIDTH-1:0] count_q;
   logic                   pop;
   logic                   full;
   logic                   empty;

   assign pop = (state_q == START) && done;

   job_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (in_valid),
      .rd_en   (pop),
      .wr_data (in_data),
      .rd_data (job_data),
      .full    (full),
      .empty   (empty)
   );

   assign in_ready  = !full;
   assign go        = go_q;
   assign busy      = busy_q;
   assign job_count = count_q;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (pending_q) state_d = START;
         START:   if (done) state_d = CLEAR;
         CLEAR:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Occupancy is sampled one edge before it can start a job, so a push into an
   // idle dispatcher raises go two edges later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         pending_q <= 1'b0;
         go_q      <= 1'b0;
         busy_q    <= 1'b0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= !empty;
         go_q      <= (state_d == START);
         busy_q    <= (state_d != IDLE);
         if (pop) count_q <= count_q + COUNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_job_dispatcher.sv
// Bench for job_dispatcher: directed scenarios plus random traffic, all checked
// against a queue-level reference model of the dispatch rules.
module tb_job_dispatcher;

   localparam int DW    = 8;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          done;

   logic          in_ready, go, busy;
   logic [DW-1:0] job_data;
   logic [15:0]   job_count;
   logic          in_ready_w, go_w, busy_w;
   logic [DW-1:0] job_data_w;
   logic [1:0]    job_count_w;

   always #5 clk = ~clk;

   job_dispatcher #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .COUNT_WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .go(go), .done(done), .job_data(job_data), .busy(busy),
      .job_count(job_count)
   );

   job_dispatcher #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .COUNT_WIDTH(2)) dut_w (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
      .in_data(in_data), .go(go_w), .done(done), .job_data(job_data_w), .busy(busy_w),
      .job_count(job_count_w)
   );

   // Reference model: job queue, dispatch flag, post-completion hold-off and count.
   logic [DW-1:0] q[$];
   bit            go_m, clear_m, busy_m;
   int            sz_lag;
   int unsigned   cnt_m;

   int checks = 0;
   int passed = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic check_all();
      chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
      chk("go", 32'(go), 32'(go_m));
      chk("busy", 32'(busy), 32'(busy_m));
      chk("job_count", 32'(job_count), 32'(cnt_m[15:0]));
      chk("in_ready_w", 32'(in_ready_w), 32'(q.size() < DEPTH));
      chk("go_w", 32'(go_w), 32'(go_m));
      chk("busy_w", 32'(busy_w), 32'(busy_m));
      chk("job_count_w", 32'(job_count_w), 32'(cnt_m % 4));
      if (go_m) begin
         chk("job_data", 32'(job_data), 32'(q[0]));
         chk("job_data_w", 32'(job_data_w), 32'(q[0]));
      end
   endtask

   // Drive one cycle of inputs, advance the model across the edge, then check.
   task automatic cycle(input bit v, input logic [DW-1:0] d, input bit dn);
      bit pop, push, go_n;
      int seen;
      logic [DW-1:0] head;
      in_valid = v;
      in_data  = d;
      done     = dn;
      pop  = go_m && dn;
      push = v && ((q.size() < DEPTH) || pop);
      seen   = sz_lag;
      sz_lag = q.size();
      if (pop) begin
         head = q.pop_front();
         cnt_m++;
      end
      if (push) q.push_back(d);
      // A job starts once the queue was seen non-empty two edges back and
      // the downstream has had its one-cycle go-low after the last completion.
      go_n    = go_m ? !pop : (!clear_m && seen > 0);
      busy_m  = go_n || pop;
      clear_m = pop;
      go_m    = go_n;
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic apply_reset();
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      done     = 1'b0;
      #1;
      q.delete();
      go_m = 0; clear_m = 0; busy_m = 0; sz_lag = 0; cnt_m = 0;
      chk("rst_go", 32'(go), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_job_count", 32'(job_count), 32'd0);
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [DW-1:0] order[$];
      logic [DW-1:0] exp_order[5];
      int            low;
      int            ndone;
      bit            measured;
      bit            dn;

      apply_reset();

      // Single job A5: go two edges after the push, done five cycles later.
      cycle(1, 8'hA5, 0);
      cycle(0, 8'h00, 0);
      chk("lat_n1_go", 32'(go), 32'd0);
      cycle(0, 8'h00, 0);
      chk("lat_n2_go", 32'(go), 32'd1);
      chk("single_data", 32'(job_data), 32'hA5);
      for (int i = 0; i < 4; i++) cycle(0, 8'h00, 0);
      cycle(0, 8'h00, 1);
      chk("single_clear_go", 32'(go), 32'd0);
      chk("single_count", 32'(job_count), 32'd1);
      cycle(0, 8'h00, 0);
      chk("single_idle_busy", 32'(busy), 32'd0);

      // Fill with 1..5 while done is held low; 5 must be dropped.
      for (int i = 1; i <= 5; i++) begin
         cycle(1, 8'(i), 0);
         if (i == 4) chk("fill_ready_low", 32'(in_ready), 32'd0);
      end
      // Job 6 offered on the completion edge of job 1 while full.
      chk("full_head", 32'(job_data), 32'd1);
      order.push_back(job_data);
      cycle(1, 8'd6, 1);
      chk("pushpop_ready", 32'(in_ready), 32'd0);
      for (int i = 0; i < 40; i++) begin
         if (go) order.push_back(job_data);
         cycle(0, 8'h00, 1);
      end
      exp_order = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd6};
      chk("order_len", 32'(order.size()), 32'd5);
      for (int i = 0; i < 5; i++) begin
         if (i < order.size()) chk("order", 32'(order[i]), 32'(exp_order[i]));
      end
      chk("fill_count", 32'(job_count), 32'd6);

      // Two queued jobs: go low exactly two cycles between them.
      cycle(1, 8'd7, 0);
      cycle(1, 8'd8, 0);
      low = 0; ndone = 0; measured = 0;
      for (int i = 0; i < 30; i++) begin
         dn = go;
         cycle(0, 8'h00, dn);
         if (dn) ndone++;
         if (ndone == 1 && !go) low++;
         if (ndone == 1 && go && !measured) begin
            chk("restart_gap", 32'(low), 32'd2);
            measured = 1;
         end
      end
      chk("restart_seen", 32'(measured), 32'd1);

      // Reset between edges while in START with three jobs queued.
      cycle(1, 8'd9, 0);
      cycle(1, 8'd10, 0);
      cycle(1, 8'd11, 0);
      chk("mid_go_before", 32'(go), 32'd1);
      #3;
      apply_reset();
      for (int i = 0; i < 5; i++) cycle(0, 8'h00, 0);
      chk("post_rst_go", 32'(go), 32'd0);
      chk("post_rst_count", 32'(job_count), 32'd0);
      chk("post_rst_ready", 32'(in_ready), 32'd1);

      // Random traffic.
      for (int i = 0; i < 400; i++)
         cycle(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 3) == 0);

      // Counter wrap: five completions on a 2-bit counter read back as 1.
      #1;
      apply_reset();
      for (int i = 0; i < 5; i++) cycle(1, 8'($urandom), 1);
      for (int i = 0; i < 30; i++) cycle(0, 8'h00, 1);
      chk("wrap_count16", 32'(job_count), 32'd5);
      chk("wrap_count2", 32'(job_count_w), 32'd1);
      for (int i = 0; i < 3; i++) cycle(0, 8'h00, 1);
      chk("idle_done_count", 32'(job_count_w), 32'd1);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
